// File: rtl/ram32x4_writer.sv
// ram32x4_writer
//   Write-port controller for the 32x4 dual-port RAM. Two write sources share
//   the port: an automatic fill of all 32 words with a fixed pattern, started
//   after reset or on a fill_req edge, and a manual write of switch data to a
//   switch address, triggered by a debounced push button.
//
// Ports
//   CLOCK2_50  in   system clock, all logic on the rising edge
//   resetn     in   asynchronous active-low reset
//   wr_key_n   in   raw push button, active-low, bouncing, asynchronous
//   fill_req   in   asynchronous level, synced rising edge requests a fill
//   sw_addr    in   [4:0] manual write address
//   sw_data    in   [3:0] manual write data
//   wr_addr    out  [4:0] RAM write address
//   wr_data    out  [3:0] RAM write data
//   wr_en      out  RAM write enable, one cycle per word
//   busy       out  high in FILL, WRITE and WAIT_RELEASE
//   wr_count   out  [5:0] manual write count, saturates at 63
module ram32x4_writer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit FILL_ON_RESET   = 1'b1
) (
  input  logic       CLOCK2_50,
  input  logic       resetn,
  input  logic       wr_key_n,
  input  logic       fill_req,
  input  logic [4:0] sw_addr,
  input  logic [3:0] sw_data,
  output logic [4:0] wr_addr,
  output logic [3:0] wr_data,
  output logic       wr_en,
  output logic       busy,
  output logic [5:0] wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_WAIT_REL} state_t;

  localparam state_t RESET_STATE = FILL_ON_RESET ? S_FILL : S_IDLE;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_key_s1, r_key_s2;
  logic          r_fill_s1, r_fill_s2, r_fill_s3;
  logic          w_fill_edge;
  logic [CW-1:0] r_db_cnt;
  logic          r_key_db, r_key_db_d;
  logic          r_press, r_release;
  logic          r_fill_pend;

  state_t        r_state, w_state_next;
  logic [4:0]    r_wr_addr, w_wr_addr_next;
  logic [3:0]    r_wr_data, w_wr_data_next;
  logic          r_wr_en, w_wr_en_next;
  logic [5:0]    r_wr_count, w_wr_count_next;

  function automatic logic [3:0] fill_pattern(input logic [4:0] a);
    return a[3:0] ^ {3'b000, a[4]};
  endfunction

  // Two-flop synchronizers; a third fill flop gives the rising-edge detect.
  always_ff @(posedge CLOCK2_50 or negedge resetn) begin
    if (!resetn) begin
      r_key_s1  <= 1'b1;
      r_key_s2  <= 1'b1;
      r_fill_s1 <= 1'b0;
      r_fill_s2 <= 1'b0;
      r_fill_s3 <= 1'b0;
    end else begin
      r_key_s1  <= wr_key_n;
      r_key_s2  <= r_key_s1;
      r_fill_s1 <= fill_req;
      r_fill_s2 <= r_fill_s1;
      r_fill_s3 <= r_fill_s2;
    end
  end

  assign w_fill_edge = r_fill_s2 & ~r_fill_s3;

  // Debounce: key_db only follows the synced key after it has differed for
  // DEBOUNCE_CYCLES consecutive samples. Press/release pulses are registered
  // from the key_db history so they last exactly one cycle.
  always_ff @(posedge CLOCK2_50 or negedge resetn) begin
    if (!resetn) begin
      r_db_cnt   <= '0;
      r_key_db   <= 1'b1;
      r_key_db_d <= 1'b1;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
    end else begin
      r_key_db_d <= r_key_db;
      r_press    <= r_key_db_d & ~r_key_db;
      r_release  <= ~r_key_db_d & r_key_db;
      if (r_key_s2 == r_key_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_key_db <= ~r_key_db;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // Pending fill request: cleared on entry to FILL, edges during FILL ignored.
  always_ff @(posedge CLOCK2_50 or negedge resetn) begin
    if (!resetn) begin
      r_fill_pend <= 1'b0;
    end else if (r_state == S_IDLE && r_fill_pend) begin
      r_fill_pend <= 1'b0;
    end else if (w_fill_edge && r_state != S_FILL) begin
      r_fill_pend <= 1'b1;
    end
  end

  // State and registered outputs; outputs change on the same edge as the
  // state so wr_en is high exactly while in FILL or WRITE.
  always_ff @(posedge CLOCK2_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= RESET_STATE;
      r_wr_addr  <= 5'd0;
      r_wr_data  <= 4'd0;
      r_wr_en    <= 1'b0;
      r_wr_count <= 6'd0;
    end else begin
      r_state    <= w_state_next;
      r_wr_addr  <= w_wr_addr_next;
      r_wr_data  <= w_wr_data_next;
      r_wr_en    <= w_wr_en_next;
      r_wr_count <= w_wr_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:     if (r_wr_en && r_wr_addr == 5'd31) w_state_next = S_IDLE;
      S_IDLE: begin
        if (r_fill_pend)  w_state_next = S_FILL;
        else if (r_press) w_state_next = S_WRITE;
      end
      S_WRITE:    w_state_next = S_WAIT_REL;
      S_WAIT_REL: if (r_release) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_addr_next  = r_wr_addr;
    w_wr_data_next  = r_wr_data;
    w_wr_en_next    = 1'b0;
    w_wr_count_next = r_wr_count;
    case (r_state)
      S_FILL: begin
        if (!r_wr_en) begin
          // First cycle after a reset that lands in FILL: write word 0.
          w_wr_addr_next = 5'd0;
          w_wr_data_next = fill_pattern(5'd0);
          w_wr_en_next   = 1'b1;
        end else if (r_wr_addr == 5'd31) begin
          w_wr_addr_next = 5'd0;
          w_wr_data_next = 4'd0;
        end else begin
          w_wr_addr_next = r_wr_addr + 5'd1;
          w_wr_data_next = fill_pattern(r_wr_addr + 5'd1);
          w_wr_en_next   = 1'b1;
        end
      end
      S_IDLE: begin
        if (r_fill_pend) begin
          w_wr_addr_next = 5'd0;
          w_wr_data_next = fill_pattern(5'd0);
          w_wr_en_next   = 1'b1;
        end else if (r_press) begin
          w_wr_addr_next = sw_addr;
          w_wr_data_next = sw_data;
          w_wr_en_next   = 1'b1;
        end
      end
      S_WRITE: begin
        if (r_wr_count != 6'd63) w_wr_count_next = r_wr_count + 6'd1;
      end
      default: ;
    endcase
  end

  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_en    = r_wr_en;
  assign wr_count = r_wr_count;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram32x4_writer.sv
module tb_ram32x4_writer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_key_n;
  logic       fill_req;
  logic [4:0] sw_addr;
  logic [3:0] sw_data;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_en;
  logic       busy;
  logic [5:0] wr_count;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_log    = 0;
  int log_addr [1024];
  int log_data [1024];
  int log_cyc  [1024];
  int ram      [32];
  int base, base2, c0, k;

  // Hand-written fill pattern: 0..15 then pairs swapped.
  int fill_tab [32] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                        1, 0, 3, 2, 5, 4, 7, 6, 9, 8, 11, 10, 13, 12, 15, 14};

  ram32x4_writer #(.DEBOUNCE_CYCLES(4), .FILL_ON_RESET(1'b1)) dut (
    .CLOCK2_50(clk),
    .resetn   (resetn),
    .wr_key_n (wr_key_n),
    .fill_req (fill_req),
    .sw_addr  (sw_addr),
    .sw_data  (sw_data),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Write monitor: every enabled cycle goes into the log and the model RAM.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr[n_log] = int'(wr_addr);
      log_data[n_log] = int'(wr_data);
      log_cyc[n_log]  = cyc;
      n_log++;
      ram[wr_addr] = int'(wr_data);
      if (busy !== 1'b1) check("busy_during_wr", busy, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int j = 0;
    while (busy === 1'b1 && j < maxc) begin
      tick(1);
      j++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_log(input string tag, input int target, input int maxc);
    int j = 0;
    while (n_log < target && j < maxc) begin
      tick(1);
      j++;
    end
    check(tag, n_log, target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; wr_key_n = 1'b1; fill_req = 1'b0; sw_addr = '0; sw_data = '0;
    tick(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_busy", busy, 1);

    // 1: fill after reset release
    base = n_log;
    resetn = 1'b1;
    wait_idle("t1_fill_done", 60);
    check("t1_words", n_log - base, 32);
    for (int i = 0; i < 32; i++) begin
      check("t1_addr", log_addr[base+i], i);
      check("t1_data", log_data[base+i], fill_tab[i]);
      check("t1_consec", log_cyc[base+i] - log_cyc[base], i);
      check("t1_ram", ram[i], fill_tab[i]);
    end

    // 2: clean manual press, latency DEBOUNCE_CYCLES+4 = 8
    sw_addr = 5'd17; sw_data = 4'hA;
    tick(2);
    base = n_log; c0 = cyc;
    wr_key_n = 1'b0;
    wait_log("t2_wait_wr", base + 1, 20);
    check("t2_latency", log_cyc[base] - c0, 8);
    check("t2_addr", log_addr[base], 17);
    check("t2_data", log_data[base], 10);
    tick(3);
    check("t2_count", wr_count, 1);
    check("t2_busy_held", busy, 1);
    check("t2_single", n_log - base, 1);
    wr_key_n = 1'b1;
    tick(7);
    check("t2_busy_pre_rel", busy, 1);
    tick(1);
    check("t2_busy_post_rel", busy, 0);

    // 3: bounce rejection, then a real press held long
    sw_addr = 5'd3; sw_data = 4'h5;
    tick(5);
    base = n_log;
    for (int i = 0; i < 5; i++) begin
      wr_key_n = 1'b0; tick(3);
      wr_key_n = 1'b1; tick(3);
    end
    tick(10);
    check("t3_bounce_nowr", n_log - base, 0);
    check("t3_bounce_count", wr_count, 1);
    check("t3_bounce_busy", busy, 0);
    wr_key_n = 1'b0;
    tick(10);
    check("t3_one_wr", n_log - base, 1);
    check("t3_addr", log_addr[base], 3);
    check("t3_data", log_data[base], 5);
    tick(100);
    check("t3_no_second", n_log - base, 1);
    wr_key_n = 1'b1;
    tick(12);
    check("t3_idle", busy, 0);
    check("t3_count", wr_count, 2);

    // 4: press debounced during FILL is discarded
    base = n_log; c0 = cyc;
    fill_req = 1'b1;
    tick(5);
    fill_req = 1'b0;
    wr_key_n = 1'b0;
    tick(50);
    check("t4_words", n_log - base, 32);
    check("t4_fill_lat", log_cyc[base] - c0, 4);
    check("t4_first_addr", log_addr[base], 0);
    check("t4_last_addr", log_addr[base+31], 31);
    check("t4_last_data", log_data[base+31], 14);
    check("t4_count", wr_count, 2);
    check("t4_not_serviced", busy, 0);
    wr_key_n = 1'b1;
    tick(12);
    sw_addr = 5'd31; sw_data = 4'hF;
    base2 = n_log;
    wr_key_n = 1'b0;
    tick(10);
    check("t4_repress_wr", n_log - base2, 1);
    check("t4_repress_addr", log_addr[base2], 31);
    check("t4_repress_data", log_data[base2], 15);
    wr_key_n = 1'b1;
    tick(12);
    check("t4_count2", wr_count, 3);
    check("t4_idle", busy, 0);

    // 5a: fill request during WAIT_RELEASE, serviced after release
    sw_addr = 5'd8; sw_data = 4'h6;
    base = n_log;
    wr_key_n = 1'b0;
    tick(10);
    check("t5_wr", n_log - base, 1);
    check("t5_wr_addr", log_addr[base], 8);
    fill_req = 1'b1;
    tick(4);
    fill_req = 1'b0;
    tick(20);
    check("t5_held_nofill", n_log - base, 1);
    check("t5_held_busy", busy, 1);
    c0 = cyc;
    wr_key_n = 1'b1;
    wait_log("t5_fill_wait", base + 33, 60);
    wait_idle("t5_fill_done", 10);
    check("t5_words", n_log - base, 33);
    check("t5_rel_to_fill", log_cyc[base+1] - c0, 9);
    check("t5_fill_first", log_addr[base+1], 0);
    check("t5_ram8", ram[8], 8);
    check("t5_count", wr_count, 4);

    // 5b: fill edge and press in the same IDLE cycle -> fill wins, press lost
    tick(5);
    base = n_log;
    wr_key_n = 1'b0;
    tick(4);
    c0 = cyc;
    fill_req = 1'b1;
    tick(4);
    fill_req = 1'b0;
    tick(45);
    check("t5b_words", n_log - base, 32);
    check("t5b_first_addr", log_addr[base], 0);
    check("t5b_fill_lat", log_cyc[base] - c0, 4);
    check("t5b_count", wr_count, 4);
    check("t5b_idle", busy, 0);
    wr_key_n = 1'b1;
    tick(12);

    // 6: reset in the middle of a fill, then restart from word 0
    fill_req = 1'b1;
    tick(4);
    fill_req = 1'b0;
    k = 0;
    while (!(wr_en === 1'b1 && wr_addr == 5'd12) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("t6_reach12", wr_addr, 12);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_wr_en", wr_en, 0);
    check("t6_rst_addr", wr_addr, 0);
    check("t6_rst_count", wr_count, 0);
    check("t6_rst_busy", busy, 1);
    tick(2);
    base = n_log;
    resetn = 1'b1;
    wait_idle("t6_refill_done", 60);
    check("t6_words", n_log - base, 32);
    check("t6_first_addr", log_addr[base], 0);
    check("t6_last_addr", log_addr[base+31], 31);

    // 64 manual writes, count saturates at 63
    base2 = n_log;
    for (int i = 0; i < 64; i++) begin
      sw_addr = 5'(i);
      sw_data = 4'(i + 1);
      wr_key_n = 1'b0;
      tick(12);
      wr_key_n = 1'b1;
      tick(12);
      if (i == 62) check("t6_count63", wr_count, 63);
    end
    check("t6_count_sat", wr_count, 63);
    check("t6_manual_words", n_log - base2, 64);
    check("t6_last_manual_addr", log_addr[base2+63], 31);
    check("t6_last_manual_data", log_data[base2+63], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
